led_shifter_driver: RTL

Serialises two 8-bit segment patterns onto a pair of daisy-free 74HC164-style shift registers (digit A, digit B), generating data, shift clock and active-low master reset. It sits between the digit/segment encoder and the board pins (`oled_dc`, `oled_mosi`, `oled_clk`, `oled_resn`). The encoder hands over one frame per display update through a valid/ready handshake. Both shifters share one shift clock and one clear line, so the block shifts both bytes in lockstep.

---
 rtl/led_shifter_driver.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/led_shifter_driver.sv
// Drives two 74HC164-style shifters in lockstep from 8-bit segment frames.
// Optional LED_SHIFTER_CLEAR_EN adds a master-reset pulse before each frame.
module led_shifter_driver #(
  parameter int CLK_DIV   = 4,
  parameter int DIV_WIDTH = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_data_a,
  input  logic [7:0] i_data_b,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_done,
  output logic       o_shifter_a_ds,
  output logic       o_shifter_b_ds,
  output logic       o_shifter_cp,
  output logic       o_shifter_mr_n
);

`ifdef LED_SHIFTER_CLEAR_EN
  typedef enum logic [2:0] {
    S_RST, S_IDLE, S_CLEAR, S_SETUP, S_HIGH
  } state_t;
`else
  typedef enum logic [2:0] {
    S_RST, S_IDLE, S_SETUP, S_HIGH
  } state_t;
`endif

  localparam logic [DIV_WIDTH-1:0] DIV_LAST =
    DIV_WIDTH'(CLK_DIV - 1);

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [7:0]           sh_a_q, sh_a_d;
  logic [7:0]           sh_b_q, sh_b_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic                 ds_a_q, ds_a_d;
  logic                 ds_b_q, ds_b_d;
  logic                 cp_q, cp_d;
  logic                 mr_n_q, mr_n_d;
  logic                 div_end;

  assign div_end = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_RST: state_d = S_IDLE;
      S_IDLE: begin
        if (i_valid) begin
          sh_a_d = i_data_a;
          sh_b_d = i_data_b;
          cnt_d  = 3'd7;
`ifdef LED_SHIFTER_CLEAR_EN
          state_d = S_CLEAR;
`else
          state_d = S_SETUP;
`endif
        end
      end
`ifdef LED_SHIFTER_CLEAR_EN
      S_CLEAR: if (div_end) state_d = S_SETUP;
`endif
      S_SETUP: if (div_end) state_d = S_HIGH;
      S_HIGH: begin
        if (div_end) begin
          if (cnt_q == 3'd0) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_q - 3'd1;
            state_d = S_SETUP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Divider restarts on every state change and idles at zero.
  always_comb begin
    div_d = div_q + 1'b1;
    if (state_d != state_q || state_q == S_IDLE)
      div_d = '0;
  end

  // Outputs are a function of the state being entered.
  always_comb begin
    ready_d = (state_d == S_IDLE);
    done_d  = (state_q == S_HIGH) && (state_d == S_IDLE);
    cp_d    = (state_d == S_HIGH);
`ifdef LED_SHIFTER_CLEAR_EN
    mr_n_d  = (state_d != S_CLEAR);
`else
    mr_n_d  = 1'b1;
`endif
    ds_a_d  = 1'b0;
    ds_b_d  = 1'b0;
    if (state_d == S_SETUP) begin
      ds_a_d = sh_a_d[cnt_d];
      ds_b_d = sh_b_d[cnt_d];
    end else if (state_d == S_HIGH) begin
      ds_a_d = ds_a_q;
      ds_b_d = ds_b_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_RST;
      div_q   <= '0;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      ds_a_q  <= 1'b0;
      ds_b_q  <= 1'b0;
      cp_q    <= 1'b0;
      mr_n_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      ds_a_q  <= ds_a_d;
      ds_b_q  <= ds_b_d;
      cp_q    <= cp_d;
      mr_n_q  <= mr_n_d;
    end
  end

  assign o_ready        = ready_q;
  assign o_done         = done_q;
  assign o_shifter_a_ds = ds_a_q;
  assign o_shifter_b_ds = ds_b_q;
  assign o_shifter_cp   = cp_q;
  assign o_shifter_mr_n = mr_n_q;

endmodule
